// File: rtl/fir_coef_pkg.sv
// rtl/fir_coef_pkg.sv - shared widths and loader state encoding for the FIR coefficient loader
package fir_coef_pkg;

  localparam int COEF_W_DEF = 18;
  localparam int ADDR_W_DEF = 8;
  localparam int CSUM_W     = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_coef_loader_if.sv
// rtl/fir_coef_loader_if.sv - host write / filter read bundle of the coefficient loader (checksum under COEF_CHECKSUM_EN)
interface fir_coef_loader_if
  import fir_coef_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              start;
  logic [COEF_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] address;
  logic [COEF_W-1:0] q;
  logic              loading;
  logic              done;
`ifdef COEF_CHECKSUM_EN
  logic [CSUM_W-1:0] checksum;
`endif

  // Host and filter side together: drives commands and read address.
  modport master (
    output start, wr_data, wr_valid, address,
    input  wr_ready, q, loading, done
`ifdef COEF_CHECKSUM_EN
    , input checksum
`endif
  );

  // Loader side.
  modport slave (
    input  start, wr_data, wr_valid, address,
    output wr_ready, q, loading, done
`ifdef COEF_CHECKSUM_EN
    , output checksum
`endif
  );

endinterface

// File: rtl/fir_coef_ram.sv
// rtl/fir_coef_ram.sv - simple dual-port coefficient store, one write port and one registered read port
module fir_coef_ram #(
  parameter int COEF_W = 18,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COEF_W-1:0] rd_data
);

`ifdef XILINX_IMPLEMENTATION
  (* ram_style = "block" *) logic [COEF_W-1:0] mem [2**ADDR_W];
`elsif ALTERA_IMPLEMENTATION
  (* ramstyle = "no_rw_check" *) logic [COEF_W-1:0] mem [2**ADDR_W];
`else
  logic [COEF_W-1:0] mem [2**ADDR_W];
`endif

  // Write and registered read share one edge; a same-address read sees the old word.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - loads a coefficient table from the host and serves it to the filter; COEF_CHECKSUM_EN adds a 24-bit checksum
module fir_coef_loader
  import fir_coef_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clock,
  input  logic               rst_n,
  fir_coef_loader_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ready_r;
  logic              loading_r;
  logic              done_r;
  logic              wr_en;
  logic              q_en;
  logic [COEF_W-1:0] rd_data;

  // A start in the same cycle as a word aborts the load, so that word is dropped.
  assign wr_en = bus.wr_valid & wr_ready_r & ~bus.start;

  // Load sequencer: start always restarts at address 0; the last word closes the table.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_addr    <= '0;
      wr_ready_r <= 1'b0;
      loading_r  <= 1'b0;
      done_r     <= 1'b0;
    end else if (bus.start) begin
      state      <= LOAD;
      wr_addr    <= '0;
      wr_ready_r <= 1'b1;
      loading_r  <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.wr_valid) begin
            wr_addr <= wr_addr + 1'b1;
            if (wr_addr == LAST_ADDR) begin
              state      <= DONE;
              wr_ready_r <= 1'b0;
              loading_r  <= 1'b0;
              done_r     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Holds q at zero from reset until the read register has sampled a real address.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q_en <= 1'b0;
    end else begin
      q_en <= 1'b1;
    end
  end

  fir_coef_ram #(
    .COEF_W (COEF_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .we      (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (bus.address),
    .rd_data (rd_data)
  );

  assign bus.q        = q_en ? rd_data : '0;
  assign bus.wr_ready = wr_ready_r;
  assign bus.loading  = loading_r;
  assign bus.done     = done_r;

`ifdef COEF_CHECKSUM_EN
  logic [CSUM_W-1:0] csum;

  // Running sum of accepted words, sign-extended, wrapping at 2**24.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (bus.start) begin
      csum <= '0;
    end else if (wr_en) begin
      csum <= csum + {{(CSUM_W-COEF_W){bus.wr_data[COEF_W-1]}}, bus.wr_data};
    end
  end

  assign bus.checksum = csum;
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - directed checks of the coefficient loader; checksum cases under COEF_CHECKSUM_EN
module tb_fir_coef_loader;

  localparam int W = 18;
  localparam int A = 8;
  localparam int N = 256;

  logic clock = 1'b0;
  logic rst_n = 1'b1;

  fir_coef_loader_if bus ();

  fir_coef_loader dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] model [N];

  typedef struct {
    int           phase;
    string        name;
    logic [A-1:0] addr;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic load_words(input logic [W-1:0] base, input int step, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      bus.wr_data  = base + W'(step * i);
      bus.wr_valid = 1'b1;
      model[i]     = bus.wr_data;
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic readback_all(input string tag);
    for (int a = 0; a < N; a++) begin
      bus.address = A'(a);
      tick();
      check($sformatf("%s_q%0d", tag, a), 32'(bus.q), 32'(model[a]));
    end
  endtask

  task automatic run_vecs(input int phase);
    foreach (vecs[k]) begin
      if (vecs[k].phase == phase) begin
        bus.address = vecs[k].addr;
        tick();
        check(vecs[k].name, 32'(bus.q), 32'(vecs[k].exp));
      end
    end
  endtask

  initial begin
    int bad;

    vecs.push_back('{1, "s1_a0",   8'd0,   18'h00000});
    vecs.push_back('{1, "s1_a77",  8'd77,  18'h0004D});
    vecs.push_back('{1, "s1_a255", 8'd255, 18'h000FF});
    vecs.push_back('{2, "s2_a0",   8'd0,   18'h3FFFF});
    vecs.push_back('{2, "s2_a1",   8'd1,   18'h3FFFE});
    vecs.push_back('{2, "s2_a100", 8'd100, 18'h3FF9B});
    vecs.push_back('{2, "s2_a128", 8'd128, 18'h3FF7F});
    vecs.push_back('{2, "s2_a255", 8'd255, 18'h3FF00});
    vecs.push_back('{3, "s3_a100", 8'd100, 18'h20064});
    vecs.push_back('{3, "s3_a255", 8'd255, 18'h200FF});

    bus.start    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.address  = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    check("rst_loading",  32'(bus.loading),  32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_q",        32'(bus.q),        32'd0);
`ifdef COEF_CHECKSUM_EN
    check("rst_checksum", 32'(bus.checksum), 32'd0);
`endif
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("idle_wr_ready", 32'(bus.wr_ready), 32'd0);

    // Full load, value = index, wr_valid held high
    pulse_start();
    check("s1_loading", 32'(bus.loading),  32'd1);
    check("s1_ready",   32'(bus.wr_ready), 32'd1);
    load_words(18'h0, 1, 0, N - 1);
    check("s1_done_before_last", 32'(bus.done), 32'd0);
    load_words(18'h0, 1, N - 1, 1);
    check("s1_done",     32'(bus.done),     32'd1);
    check("s1_loading0", 32'(bus.loading),  32'd0);
    check("s1_ready0",   32'(bus.wr_ready), 32'd0);
    // Words presented in DONE are ignored
    bus.wr_valid = 1'b1;
    bus.wr_data  = 18'h2AAAA;
    repeat (3) tick();
    bus.wr_valid = 1'b0;
    check("s1_done_hold", 32'(bus.done), 32'd1);
    run_vecs(1);
    readback_all("s1");

    // Load with wr_valid toggling, values 0x3FFFF - index
    pulse_start();
    bad = 0;
    for (int i = 0; i < N; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 18'h3FFFF - W'(i);
      model[i]     = bus.wr_data;
      if (bus.wr_ready !== 1'b1 || bus.loading !== 1'b1 || bus.done !== 1'b0) bad++;
      tick();
      bus.wr_valid = 1'b0;
      if (i < N - 1) begin
        if (bus.wr_ready !== 1'b1 || bus.loading !== 1'b1 || bus.done !== 1'b0) bad++;
        tick();
      end
    end
    check("s2_ready_or_done_glitches", 32'(bad), 32'd0);
    check("s2_done", 32'(bus.done), 32'd1);
    run_vecs(2);
    readback_all("s2");

    // Abort after 100 words, with a word presented on the start cycle, then reload
    pulse_start();
    load_words(18'h11111, 1, 0, 100);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 18'h15555;
    pulse_start();
    bus.wr_valid = 1'b0;
    check("s3_restart_loading", 32'(bus.loading), 32'd1);
    check("s3_restart_done",    32'(bus.done),    32'd0);
    bus.address = 8'd100;
    tick();
    check("s3_abort_word_dropped", 32'(bus.q), 32'h3FF9B);
    load_words(18'h20000, 1, 0, N - 1);
    check("s3_done_before_last", 32'(bus.done), 32'd0);
    load_words(18'h20000, 1, N - 1, 1);
    check("s3_done", 32'(bus.done), 32'd1);
    run_vecs(3);
    readback_all("s3");

    // Read-during-write on address 5
    bus.address = 8'd5;
    pulse_start();
    for (int i = 0; i < N; i++) begin
      bus.wr_data  = 18'h00A00 + W'(i);
      bus.wr_valid = 1'b1;
      model[i]     = bus.wr_data;
      tick();
      if (i == 4) check("s4_before", 32'(bus.q), 32'h20005);
      if (i == 5) check("s4_rdw_old", 32'(bus.q), 32'h20005);
      if (i == 6) check("s4_rdw_new", 32'(bus.q), 32'h00A05);
    end
    bus.wr_valid = 1'b0;
    check("s4_done", 32'(bus.done), 32'd1);

`ifdef COEF_CHECKSUM_EN
    // Checksum: all -1 words, then all +1 words
    pulse_start();
    check("cs_clear_on_start", 32'(bus.checksum), 32'd0);
    load_words(18'h3FFFF, 0, 0, N);
    check("cs_neg_done", 32'(bus.done), 32'd1);
    check("cs_neg", 32'(bus.checksum), 32'hFFFF00);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 18'h00123;
    repeat (4) tick();
    bus.wr_valid = 1'b0;
    check("cs_neg_stable", 32'(bus.checksum), 32'hFFFF00);
    pulse_start();
    load_words(18'h00001, 0, 0, N);
    check("cs_pos", 32'(bus.checksum), 32'h000100);
`endif

    // Asynchronous reset in the middle of a load
    pulse_start();
    load_words(18'h12300, 1, 0, 50);
    bus.address  = 8'd0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 18'h00007;
    #3 rst_n = 1'b0;
    #1;
    check("s5_rst_loading",  32'(bus.loading),  32'd0);
    check("s5_rst_ready",    32'(bus.wr_ready), 32'd0);
    check("s5_rst_done",     32'(bus.done),     32'd0);
    check("s5_rst_q",        32'(bus.q),        32'd0);
`ifdef COEF_CHECKSUM_EN
    check("s5_rst_checksum", 32'(bus.checksum), 32'd0);
`endif
    tick();
    #2 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.loading !== 1'b0 || bus.wr_ready !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check("s5_idle_ignores_valid", 32'(bad), 32'd0);
    check("s5_q_no_write", 32'(bus.q), 32'h12300);
    bus.wr_valid = 1'b0;
    bus.address  = 8'd60;
    tick();
    check("s5_q_old_table", 32'(bus.q), 32'(model[60]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
